// File: rtl/toy_bus_pkg.sv
// Shared toy_bus field widths, opcode encoding and route-table helper.
package toy_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ID_W   = 4;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } toy_bus_op_e;

  // Builds a four-channel route table; id0 lands in the lowest slice (channel 0).
  function automatic logic [4*ID_W-1:0] pack_tgt_table(input logic [ID_W-1:0] id0,
                                                        input logic [ID_W-1:0] id1,
                                                        input logic [ID_W-1:0] id2,
                                                        input logic [ID_W-1:0] id3);
    return {id3, id2, id1, id0};
  endfunction

endpackage

// File: rtl/toy_bus_fwd_slice.sv
// One-entry forward register slice; the consumer signals removal through drain_i.
module toy_bus_fwd_slice #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  input  logic [W-1:0] in_data_i,
  input  logic         drain_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  assign in_rdy_o = !full_q || drain_i;
  assign load     = in_vld_i && in_rdy_o;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/toy_bus_ddec_reg.sv
// Registered toy_bus request decoder: routes by tgt_id through a route table,
// drops unmapped requests with an error pulse and a saturating error count.
module toy_bus_ddec_reg
  import toy_bus_pkg::*;
#(
  parameter int unsigned               NUM_OUT      = 4,
  parameter int unsigned               ADDR_W       = toy_bus_pkg::ADDR_W,
  parameter int unsigned               DATA_W       = toy_bus_pkg::DATA_W,
  parameter int unsigned               STRB_W       = toy_bus_pkg::STRB_W,
  parameter int unsigned               ID_W         = toy_bus_pkg::ID_W,
  parameter logic [NUM_OUT*ID_W-1:0]   TGT_ID_TABLE = {4'd7, 4'd5, 4'd4, 4'd3},
  parameter int unsigned               ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in0_vld,
  output logic                 in0_rdy,
  input  logic [ADDR_W-1:0]    in0_addr,
  input  logic [STRB_W-1:0]    in0_strb,
  input  logic [DATA_W-1:0]    in0_data,
  input  logic                 in0_opcode,
  input  logic [ID_W-1:0]      in0_src_id,
  input  logic [ID_W-1:0]      in0_tgt_id,
  output logic [NUM_OUT-1:0]   out_vld,
  input  logic [NUM_OUT-1:0]   out_rdy,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [STRB_W-1:0]    out_strb,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_opcode,
  output logic [ID_W-1:0]      out_src_id,
  output logic [ID_W-1:0]      out_tgt_id,
  output logic                 err_vld,
  output logic [ID_W-1:0]      err_tgt_id,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned SEL_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int unsigned PAY_W = ADDR_W + STRB_W + DATA_W + 1 + 2 * ID_W;
  localparam int unsigned SLC_W = 1 + SEL_W + PAY_W;

  logic             dec_hit;
  logic [SEL_W-1:0] dec_sel;
  logic             full;
  logic             ent_hit;
  logic [SEL_W-1:0] ent_sel;
  logic             drain;
  logic [SLC_W-1:0] slc_data;

  // Decode happens before the slice so routing is resolved from the register.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (!dec_hit && (in0_tgt_id == TGT_ID_TABLE[i*ID_W +: ID_W])) begin
        dec_hit = 1'b1;
        dec_sel = SEL_W'(i);
      end
    end
  end

  // Unmapped entries leave unconditionally so a bad target never stalls the input.
  assign drain = full && (ent_hit ? out_rdy[ent_sel] : 1'b1);

  toy_bus_fwd_slice #(
    .W (SLC_W)
  ) u_slice (
    .clk       (clk),
    .rst       (rst),
    .in_vld_i  (in0_vld),
    .in_rdy_o  (in0_rdy),
    .in_data_i ({dec_hit, dec_sel, in0_addr, in0_strb, in0_data,
                 in0_opcode, in0_src_id, in0_tgt_id}),
    .drain_i   (drain),
    .full_o    (full),
    .data_o    (slc_data)
  );

  assign {ent_hit, ent_sel, out_addr, out_strb, out_data,
          out_opcode, out_src_id, out_tgt_id} = slc_data;

  always_comb begin
    out_vld = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      out_vld[i] = full && ent_hit && (ent_sel == SEL_W'(i));
    end
  end

  logic                 err_vld_q, err_vld_d;
  logic [ID_W-1:0]      err_tgt_q, err_tgt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_vld_d = full && !ent_hit;
    err_tgt_d = err_tgt_q;
    err_cnt_d = err_cnt_q;
    if (full && !ent_hit) begin
      err_tgt_d = out_tgt_id;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_vld_q <= 1'b0;
      err_tgt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      err_vld_q <= err_vld_d;
      err_tgt_q <= err_tgt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_vld    = err_vld_q;
  assign err_tgt_id = err_tgt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_toy_bus_ddec_reg.sv
// Scoreboard bench for toy_bus_ddec_reg: default instance A, plus instance B
// with a duplicated route entry and a 2-bit error counter.
module tb_toy_bus_ddec_reg;
  import toy_bus_pkg::*;

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        op;
    logic [3:0]  src;
    logic [3:0]  tgt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_vld, a_rdy, a_op, a_oop, a_evld;
  logic [31:0] a_addr, a_data, a_oaddr, a_odata;
  logic [3:0]  a_strb, a_src, a_tgt, a_ovld, a_ordy, a_ostrb, a_osrc, a_otgt, a_etgt;
  logic [7:0]  a_ecnt;

  logic        b_vld, b_rdy, b_op, b_oop, b_evld;
  logic [31:0] b_addr, b_data, b_oaddr, b_odata;
  logic [3:0]  b_strb, b_src, b_tgt, b_ovld, b_ordy, b_ostrb, b_osrc, b_otgt, b_etgt;
  logic [1:0]  b_ecnt;

  toy_bus_ddec_reg u_a (
    .clk(clk), .rst(rst),
    .in0_vld(a_vld), .in0_rdy(a_rdy), .in0_addr(a_addr), .in0_strb(a_strb),
    .in0_data(a_data), .in0_opcode(a_op), .in0_src_id(a_src), .in0_tgt_id(a_tgt),
    .out_vld(a_ovld), .out_rdy(a_ordy), .out_addr(a_oaddr), .out_strb(a_ostrb),
    .out_data(a_odata), .out_opcode(a_oop), .out_src_id(a_osrc), .out_tgt_id(a_otgt),
    .err_vld(a_evld), .err_tgt_id(a_etgt), .err_cnt(a_ecnt)
  );

  toy_bus_ddec_reg #(
    .NUM_OUT      (4),
    .ERR_CNT_W    (2),
    .TGT_ID_TABLE (pack_tgt_table(4'd3, 4'd5, 4'd5, 4'd7))
  ) u_b (
    .clk(clk), .rst(rst),
    .in0_vld(b_vld), .in0_rdy(b_rdy), .in0_addr(b_addr), .in0_strb(b_strb),
    .in0_data(b_data), .in0_opcode(b_op), .in0_src_id(b_src), .in0_tgt_id(b_tgt),
    .out_vld(b_ovld), .out_rdy(b_ordy), .out_addr(b_oaddr), .out_strb(b_ostrb),
    .out_data(b_odata), .out_opcode(b_oop), .out_src_id(b_osrc), .out_tgt_id(b_otgt),
    .err_vld(b_evld), .err_tgt_id(b_etgt), .err_cnt(b_ecnt)
  );

  int errors = 0;
  int checks = 0;
  exp_t qa[$], qb[$];
  logic [3:0] ea[$], eb[$];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Scoreboard monitors: a delivery is a cycle with out_vld & out_rdy.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if ((a_ovld & a_ordy) != 4'd0) begin
        if (qa.size() == 0) chk("a_unexpected_delivery", 128'(a_ovld), 128'd0);
        else begin
          e = qa.pop_front();
          chk("a_deliver_ch", 128'(a_ovld), 128'd1 << e.ch);
          chk("a_deliver_payload", 128'({a_oaddr, a_odata, a_ostrb, a_oop, a_osrc, a_otgt}),
              128'({e.addr, e.data, e.strb, e.op, e.src, e.tgt}));
        end
      end
      if (a_evld) begin
        if (ea.size() == 0) chk("a_unexpected_err", 128'(a_evld), 128'd0);
        else chk("a_err_tgt", 128'(a_etgt), 128'(ea.pop_front()));
      end
      if ((b_ovld & b_ordy) != 4'd0) begin
        if (qb.size() == 0) chk("b_unexpected_delivery", 128'(b_ovld), 128'd0);
        else begin
          e = qb.pop_front();
          chk("b_deliver_ch", 128'(b_ovld), 128'd1 << e.ch);
          chk("b_deliver_payload", 128'({b_oaddr, b_odata, b_ostrb, b_oop, b_osrc, b_otgt}),
              128'({e.addr, e.data, e.strb, e.op, e.src, e.tgt}));
        end
      end
      if (b_evld) begin
        if (eb.size() == 0) chk("b_unexpected_err", 128'(b_evld), 128'd0);
        else chk("b_err_tgt", 128'(b_etgt), 128'(eb.pop_front()));
      end
    end
  end

  // exp_ch: channel index, -1 expects an error pulse, -2 expects nothing.
  task automatic send(input bit b, input logic [3:0] tgt, input logic [31:0] addr,
                      input logic [31:0] data, input logic op, input int exp_ch,
                      output int stalls);
    exp_t e;
    e.ch = exp_ch; e.addr = addr; e.data = data; e.strb = op ? 4'hF : 4'h0;
    e.op = op; e.src = addr[3:0]; e.tgt = tgt;
    if (b) begin
      b_vld = 1'b1; b_tgt = tgt; b_addr = addr; b_data = data;
      b_strb = e.strb; b_op = op; b_src = e.src;
    end else begin
      a_vld = 1'b1; a_tgt = tgt; a_addr = addr; a_data = data;
      a_strb = e.strb; a_op = op; a_src = e.src;
    end
    if (exp_ch >= 0) begin
      if (b) qb.push_back(e); else qa.push_back(e);
    end else if (exp_ch == -1) begin
      if (b) eb.push_back(tgt); else ea.push_back(tgt);
    end
    stalls = 0;
    @(negedge clk);
    while (!(b ? b_rdy : a_rdy) && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 50) begin
      errors++; checks++;
      $display("FAIL send_timeout: in0_rdy low for %0d cycles, required acceptance", stalls);
    end
    @(posedge clk); #1;
    if (b) b_vld = 1'b0; else a_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [31:0] hold_addr;
    rst = 1'b1;
    {a_vld, a_addr, a_data, a_strb, a_op, a_src, a_tgt} = '0;
    {b_vld, b_addr, b_data, b_strb, b_op, b_src, b_tgt} = '0;
    a_ordy = 4'hF; b_ordy = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_a_out_vld", 128'(a_ovld), 128'd0);
    chk("reset_a_err_vld", 128'(a_evld), 128'd0);
    chk("reset_a_err_cnt", 128'(a_ecnt), 128'd0);
    chk("reset_a_in_rdy", 128'(a_rdy), 128'd1);
    chk("reset_b_out_vld", 128'(b_ovld), 128'd0);
    @(posedge clk); #1;

    // Basic routing: tgt 4 -> channel 1 one cycle after acceptance.
    send(0, 4'd4, 32'h1000_0045, 32'hCAFE_0001, OP_WRITE, 1, st);
    chk("t1_out_vld_latency", 128'(a_ovld), 128'h2);
    @(posedge clk); #1;
    chk("t1_err_cnt", 128'(a_ecnt), 128'd0);

    // Backpressure on channel 0, then release with a same-cycle reload.
    a_ordy = 4'b1110;
    send(0, 4'd3, 32'h2000_0033, 32'h0BAD_F00D, OP_READ, 0, st);
    hold_addr = 32'h2000_0033;
    repeat (5) begin
      @(negedge clk);
      chk("t2_hold_vld", 128'(a_ovld), 128'h1);
      chk("t2_hold_addr", 128'(a_oaddr), 128'(hold_addr));
      chk("t2_hold_in_rdy", 128'(a_rdy), 128'd0);
    end
    @(posedge clk); #1;
    a_ordy = 4'hF;
    send(0, 4'd4, 32'h2000_0044, 32'h1234_5678, OP_WRITE, 1, st);
    chk("t2_reload_no_stall", 128'(st), 128'd0);
    chk("t2_reload_vld", 128'(a_ovld), 128'h2);

    // Full-throughput stream over all channels.
    send(0, 4'd3, 32'h3000_0001, 32'hAAAA_0000, OP_WRITE, 0, st); chk("t3_stall0", 128'(st), 128'd0);
    send(0, 4'd4, 32'h3000_0002, 32'hAAAA_0001, OP_READ,  1, st); chk("t3_stall1", 128'(st), 128'd0);
    send(0, 4'd5, 32'h3000_0003, 32'hAAAA_0002, OP_WRITE, 2, st); chk("t3_stall2", 128'(st), 128'd0);
    send(0, 4'd7, 32'h3000_0004, 32'hAAAA_0003, OP_READ,  3, st); chk("t3_stall3", 128'(st), 128'd0);
    repeat (2) @(posedge clk); #1;

    // Unmapped target on A.
    send(0, 4'd9, 32'h4000_0009, 32'hDEAD_BEEF, OP_WRITE, -1, st);
    chk("t4_no_out_vld", 128'(a_ovld), 128'd0);
    repeat (3) @(posedge clk); #1;
    chk("t4_err_cnt", 128'(a_ecnt), 128'd1);

    // Five back-to-back unmapped requests saturate B's 2-bit counter.
    send(1, 4'd0, 32'h5000_0000, 32'h0, OP_WRITE, -1, st); chk("t5_stall0", 128'(st), 128'd0);
    send(1, 4'd1, 32'h5000_0001, 32'h1, OP_WRITE, -1, st); chk("t5_stall1", 128'(st), 128'd0);
    send(1, 4'd2, 32'h5000_0002, 32'h2, OP_WRITE, -1, st); chk("t5_stall2", 128'(st), 128'd0);
    send(1, 4'd6, 32'h5000_0003, 32'h3, OP_WRITE, -1, st); chk("t5_stall3", 128'(st), 128'd0);
    send(1, 4'd8, 32'h5000_0004, 32'h4, OP_WRITE, -1, st); chk("t5_stall4", 128'(st), 128'd0);
    repeat (3) @(posedge clk); #1;
    chk("t5_err_cnt_sat", 128'(b_ecnt), 128'd3);

    // Duplicate id 5 in B's table: lowest index (channel 1) wins.
    send(1, 4'd5, 32'h6000_0005, 32'h5555_5555, OP_READ, 1, st);
    chk("t6_dup_lowest", 128'(b_ovld), 128'h2);
    repeat (2) @(posedge clk); #1;

    // Reset discards a buffered request.
    a_ordy = 4'h0;
    send(0, 4'd7, 32'h7000_0007, 32'h7777_7777, OP_WRITE, -2, st);
    chk("t7_buffered_vld", 128'(a_ovld), 128'h8);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("t7_rst_out_vld", 128'(a_ovld), 128'd0);
    chk("t7_rst_in_rdy", 128'(a_rdy), 128'd1);
    chk("t7_rst_err_cnt", 128'(a_ecnt), 128'd0);
    a_ordy = 4'hF;
    repeat (3) @(posedge clk); #1;

    // Reset suppresses a pending error pulse.
    send(0, 4'd9, 32'h8000_0009, 32'h9999_9999, OP_WRITE, -2, st);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t8_err_suppressed", 128'(a_evld), 128'd0);
    chk("t8_err_cnt", 128'(a_ecnt), 128'd0);
    repeat (3) @(posedge clk); #1;

    chk("end_qa_empty", 128'(qa.size()), 128'd0);
    chk("end_qb_empty", 128'(qb.size()), 128'd0);
    chk("end_ea_empty", 128'(ea.size()), 128'd0);
    chk("end_eb_empty", 128'(eb.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toy_bus_ddec_reg.md
Name: toy_bus_ddec_reg

Overview:
- Parametrised, registered request decoder node for the toy_bus network.
- Accepts one ToyBusReq stream and routes each request to one of NUM_OUT channels via a parameter route table keyed on tgt_id.
- A one-entry forward register slice breaks the rdy/vld timing path between upstream and downstream.
- Requests whose tgt_id is unmapped are dropped, reported with a one-cycle error pulse, and counted in a saturating error counter.

Parameters:
- NUM_OUT, 4, number of output channels (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STRB_W, 4, byte strobe width (DATA_W/8).
- ID_W, 4, src_id/tgt_id width.
- TGT_ID_TABLE, {4'd7,4'd5,4'd4,4'd3}, NUM_OUT*ID_W flat table; slice i is the tgt_id routed to channel i.
- ERR_CNT_W, 8, width of the decode-error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in0_vld  in  1  request valid.
- in0_rdy  out  1  request ready.
- in0_addr  in  ADDR_W  address.
- in0_strb  in  STRB_W  strobe.
- in0_data  in  DATA_W  write data.
- in0_opcode  in  1  opcode.
- in0_src_id  in  ID_W  source id.
- in0_tgt_id  in  ID_W  target id.
- out_vld  out  NUM_OUT  per-channel valid, one-hot or zero.
- out_rdy  in  NUM_OUT  per-channel ready.
- out_addr / out_strb / out_data / out_opcode / out_src_id / out_tgt_id  out  as input  payload shared by all channels.
- err_vld  out  1  one-cycle pulse when an unmapped request is dropped.
- err_tgt_id  out  ID_W  tgt_id of the dropped request, valid with err_vld.
- err_cnt  out  ERR_CNT_W  saturating count of dropped requests.

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous and active-high.
- State:
  - full flag.
  - Payload register.
  - sel register (clog2(NUM_OUT) bits).
  - hit register (1 = mapped).
- Decode at enqueue:
  - hit_i = (in0_tgt_id == TGT_ID_TABLE[i]).
  - If several entries match, the lowest index wins.
  - sel = that index; hit = OR of all hit_i.
- Outputs:
  - out_vld[i] = full && hit && (sel == i).
  - Payload outputs are driven from the register, never from in0_* combinationally.
- Drain condition: drain = full && (hit ? out_rdy[sel] : 1). An unmapped entry always drains in its first valid cycle.
- Input ready: in0_rdy = !full || drain. Full throughput: enqueue and drain in the same cycle reloads the register with no bubble.
- Latency: an accepted request appears on out_vld exactly 1 cycle after the in0_vld && in0_rdy edge.
- Handshake rules:
  - While out_vld[i] && !out_rdy[i], the payload and out_vld stay stable.
  - The other channels' out_rdy values are ignored.
  - out_rdy on a channel with out_vld=0 has no effect.
- Error path:
  - When full && !hit, err_vld is registered high for the following cycle, with err_tgt_id = the dropped tgt_id.
  - err_cnt increments by 1 and saturates at all-ones. It stops without wrapping.
- Reset values: full=0, out_vld=0, err_vld=0, err_cnt=0. Payload, sel and err_tgt_id are don't-care but are reset to 0 for X-cleanliness.
- Reset mid-operation: a buffered request is discarded, not delivered. A pending error pulse is suppressed.
- Back-to-back unmapped requests produce one err_vld pulse and one increment each, with no stall.
- in0_vld=0 with full=0: no outputs are asserted.

Decomposition:
- toy_bus_pkg holds:
  - The ToyBusReq field widths (ADDR_W, DATA_W, STRB_W, ID_W).
  - Opcode constants (READ=0, WRITE=1).
  - A helper function pack_tgt_table.
- One natural sub-module: toy_bus_fwd_slice, a generic one-entry valid/ready register slice with a drain input. The decode and error logic live in the top.

Test Plan:
- Reset, then send tgt_id=4 with out_rdy=all-ones -> out_vld=4'b0010 one cycle later; payload matches; err_cnt=0.
- tgt_id=3, out_rdy[0]=0 for 5 cycles -> out_vld[0] held and payload stable; in0_rdy=0; release -> accepted; the next request is enqueued in the same cycle.
- Stream tgt_ids 3,4,5,7 back-to-back with all ready -> one request per cycle on channels 0,1,2,3 in order; in0_rdy stays 1.
- tgt_id=9 -> no out_vld; err_vld pulses one cycle with err_tgt_id=9; err_cnt=1. With ERR_CNT_W=2 and 5 bad requests -> err_cnt=3.
- TGT_ID_TABLE with duplicate id 5 at indices 1 and 2 -> only out_vld[1] asserts.
- Request buffered with out_rdy=0, assert rst one cycle -> out_vld=0, full cleared, the request is never delivered, err_cnt=0.
